// File: rtl/trap_sequencer.sv
// Machine-mode trap sequencer: turns exceptions, interrupts and MRET into
// mepc/mcause writes plus a fetch redirect, stalling the pipeline meanwhile.
module trap_sequencer #(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned CAUSE_W = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               excReq,
   input  logic [CAUSE_W-1:0] excCause,
   input  logic [XLEN-1:0]    excPc,
   input  logic               irqReq,
   input  logic [CAUSE_W-1:0] irqCause,
   input  logic [XLEN-1:0]    irqPc,
   input  logic               irqEn,
   input  logic               mretReq,
   input  logic [XLEN-1:0]    mtvecIn,
   input  logic [XLEN-1:0]    mepcIn,
   output logic               mepcWe,
   output logic [XLEN-1:0]    mepcDo,
   output logic               mcauseWe,
   output logic [XLEN-1:0]    mcauseDo,
   output logic               redirectValid,
   output logic [XLEN-1:0]    redirectPc,
   output logic               busy
);

   localparam int unsigned PadW = XLEN - 1 - CAUSE_W;
   localparam int unsigned OffW = XLEN - 2 - CAUSE_W;

   typedef enum logic [1:0] {StIdle, StSave, StVector, StReturn} state_e;

   state_e             state_q, state_d;
   logic [XLEN-1:0]    pc_q, pc_d;
   logic [CAUSE_W-1:0] cause_q, cause_d;
   logic               is_irq_q, is_irq_d;

   logic               irq_take;
   logic [XLEN-1:0]    vec_base;
   logic [XLEN-1:0]    vec_off;

   assign irq_take = irqReq & irqEn;
   assign vec_base = {mtvecIn[XLEN-1:2], 2'b00};
   assign vec_off  = {{OffW{1'b0}}, cause_q, 2'b00};

   // Captured values stay on the data ports; only the strobes qualify them.
   assign mepcDo   = {pc_q[XLEN-1:2], 2'b00};
   assign mcauseDo = {is_irq_q, {PadW{1'b0}}, cause_q};
   assign busy     = (state_q != StIdle);

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      cause_d       = cause_q;
      is_irq_d      = is_irq_q;
      mepcWe        = 1'b0;
      mcauseWe      = 1'b0;
      redirectValid = 1'b0;
      redirectPc    = '0;

      unique case (state_q)
         StIdle: begin
            if (excReq) begin
               pc_d     = excPc;
               cause_d  = excCause;
               is_irq_d = 1'b0;
               state_d  = StSave;
            end else if (irq_take) begin
               pc_d     = irqPc;
               cause_d  = irqCause;
               is_irq_d = 1'b1;
               state_d  = StSave;
            end else if (mretReq) begin
               state_d  = StReturn;
            end
         end
         StSave: begin
            mepcWe   = 1'b1;
            mcauseWe = 1'b1;
            state_d  = StVector;
         end
         StVector: begin
            redirectValid = 1'b1;
            // Reserved modes 2/3 fall back to direct.
            if (mtvecIn[1:0] == 2'd1 && is_irq_q) begin
               redirectPc = vec_base + vec_off;
            end else begin
               redirectPc = vec_base;
            end
            state_d = StIdle;
         end
         StReturn: begin
            redirectValid = 1'b1;
            redirectPc    = {mepcIn[XLEN-1:2], 2'b00};
            state_d       = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= StIdle;
         pc_q     <= '0;
         cause_q  <= '0;
         is_irq_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         cause_q  <= cause_d;
         is_irq_q <= is_irq_d;
      end
   end

endmodule

// File: tb/tb_trap_sequencer.sv
// Bench for trap_sequencer: a per-cycle event timeline model checked every
// cycle, plus directed literal checks and a randomized phase.
module tb_trap_sequencer;

   logic        clk      = 1'b0;
   logic        reset    = 1'b0;
   logic        excReq   = 1'b0;
   logic [3:0]  excCause = '0;
   logic [31:0] excPc    = '0;
   logic        irqReq   = 1'b0;
   logic [3:0]  irqCause = '0;
   logic [31:0] irqPc    = '0;
   logic        irqEn    = 1'b0;
   logic        mretReq  = 1'b0;
   logic [31:0] mtvecIn  = '0;
   logic [31:0] mepcIn   = '0;
   logic        mepcWe, mcauseWe, redirectValid, busy;
   logic [31:0] mepcDo, mcauseDo, redirectPc;

   int checks   = 0;
   int failures = 0;

   trap_sequencer #(.XLEN(32), .CAUSE_W(4)) dut (
      .clk(clk), .reset(reset),
      .excReq(excReq), .excCause(excCause), .excPc(excPc),
      .irqReq(irqReq), .irqCause(irqCause), .irqPc(irqPc), .irqEn(irqEn),
      .mretReq(mretReq), .mtvecIn(mtvecIn), .mepcIn(mepcIn),
      .mepcWe(mepcWe), .mepcDo(mepcDo), .mcauseWe(mcauseWe), .mcauseDo(mcauseDo),
      .redirectValid(redirectValid), .redirectPc(redirectPc), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] vec_pc(input logic [31:0] tv, input logic irq,
                                          input logic [3:0] c);
      logic [31:0] base;
      base = tv & 32'hFFFF_FFFC;
      if (tv[1:0] == 2'd1 && irq) return base + 32'(c) * 32'd4;
      return base;
   endfunction

   // Timeline model: event kind expected in each cycle (0 none, 1 save, 2 vector, 3 return).
   int          cyc     = 0;
   int          free_at = 0;
   int          ev_kind [8];
   logic        ev_irq  [8];
   logic [3:0]  ev_cause[8];
   logic [31:0] m_pc    = '0;
   logic [31:0] m_cause = '0;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 8; i++) ev_kind[i] <= 0;
         free_at <= 0;
         m_pc    <= '0;
         m_cause <= '0;
      end else begin
         cyc <= cyc + 1;
         ev_kind[cyc % 8] <= 0;
         if (cyc + 1 >= free_at) begin
            if (excReq || (irqReq && irqEn)) begin
               m_pc    <= excReq ? excPc : irqPc;
               m_cause <= excReq ? {28'd0, excCause} : (32'h8000_0000 | {28'd0, irqCause});
               ev_kind[(cyc + 1) % 8]  <= 1;
               ev_kind[(cyc + 2) % 8]  <= 2;
               ev_irq[(cyc + 2) % 8]   <= !excReq;
               ev_cause[(cyc + 2) % 8] <= excReq ? excCause : irqCause;
               free_at <= cyc + 4;
            end else if (mretReq) begin
               ev_kind[(cyc + 1) % 8] <= 3;
               free_at <= cyc + 3;
            end
         end
      end
   end

   always @(negedge clk) begin
      int k;
      logic [31:0] exp_pc;
      k = reset ? ev_kind[cyc % 8] : 0;
      exp_pc = (k == 2) ? vec_pc(mtvecIn, ev_irq[cyc % 8], ev_cause[cyc % 8]) :
               (k == 3) ? (mepcIn & 32'hFFFF_FFFC) : 32'd0;
      chk("m_busy", {31'd0, busy}, {31'd0, k != 0});
      chk("m_mepcWe", {31'd0, mepcWe}, {31'd0, k == 1});
      chk("m_mcauseWe", {31'd0, mcauseWe}, {31'd0, k == 1});
      chk("m_redirectValid", {31'd0, redirectValid}, {31'd0, k >= 2});
      chk("m_mepcDo", mepcDo, m_pc & 32'hFFFF_FFFC);
      chk("m_mcauseDo", mcauseDo, m_cause);
      if (k >= 2 || !reset) chk("m_redirectPc", redirectPc, exp_pc);
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   initial begin
      // Reset held with a pending exception.
      excReq = 1'b1; excCause = 4'd2; excPc = 32'h103; mtvecIn = 32'h100;
      repeat (3) step();
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_mepcWe", {31'd0, mepcWe}, 32'd0);
      chk("rst_mepcDo", mepcDo, 32'd0);
      chk("rst_redirectValid", {31'd0, redirectValid}, 32'd0);
      reset = 1'b1;
      step();
      chk("exc_mepcWe", {31'd0, mepcWe}, 32'd1);
      chk("exc_mepcDo", mepcDo, 32'h100);
      chk("exc_mcauseWe", {31'd0, mcauseWe}, 32'd1);
      chk("exc_mcauseDo", mcauseDo, 32'h2);
      chk("exc_busy1", {31'd0, busy}, 32'd1);
      excReq = 1'b0;
      step();
      chk("exc_rv", {31'd0, redirectValid}, 32'd1);
      chk("exc_rpc", redirectPc, 32'h100);
      chk("exc_busy2", {31'd0, busy}, 32'd1);
      step();
      chk("exc_busy3", {31'd0, busy}, 32'd0);

      // Vectored interrupt.
      irqReq = 1'b1; irqEn = 1'b1; irqCause = 4'd11; irqPc = 32'h40; mtvecIn = 32'h101;
      step();
      chk("irq_mcauseDo", mcauseDo, 32'h8000_000B);
      chk("irq_mepcDo", mepcDo, 32'h40);
      irqReq = 1'b0;
      step();
      chk("irq_rpc", redirectPc, 32'h12C);
      step();
      irqReq = 1'b1; irqEn = 1'b0;
      repeat (3) begin
         step();
         chk("irq_dis_busy", {31'd0, busy}, 32'd0);
      end
      irqReq = 1'b0;

      // Priority, then the still-pending interrupt right after the vector cycle.
      excReq = 1'b1; excCause = 4'd4; excPc = 32'h200;
      irqReq = 1'b1; irqEn = 1'b1; irqCause = 4'd3; mretReq = 1'b1;
      step();
      chk("pri_mcauseDo", mcauseDo, 32'h4);
      excReq = 1'b0; mretReq = 1'b0;
      step();
      chk("pri_rpc", redirectPc, 32'h100);
      step();
      chk("pri_idle", {31'd0, busy}, 32'd0);
      step();
      chk("pri_irq_mcauseDo", mcauseDo, 32'h8000_0003);
      irqReq = 1'b0;
      repeat (2) step();

      // MRET.
      mepcIn = 32'h82; mretReq = 1'b1;
      step();
      chk("mret_rv", {31'd0, redirectValid}, 32'd1);
      chk("mret_rpc", redirectPc, 32'h80);
      chk("mret_we", {30'd0, mepcWe, mcauseWe}, 32'd0);
      mretReq = 1'b0;
      step();
      chk("mret_busy", {31'd0, busy}, 32'd0);

      // Reset during SAVE.
      excReq = 1'b1; excCause = 4'd5; excPc = 32'h300;
      step();
      chk("mid_save", {31'd0, mepcWe}, 32'd1);
      excReq = 1'b0;
      reset = 1'b0;
      #1;
      chk("mid_busy", {31'd0, busy}, 32'd0);
      chk("mid_mepcWe", {31'd0, mepcWe}, 32'd0);
      chk("mid_mepcDo", mepcDo, 32'd0);
      step();
      chk("mid_rv", {31'd0, redirectValid}, 32'd0);
      reset = 1'b1;
      step();

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         excReq   = ($urandom_range(0, 5) == 0);
         excCause = 4'($urandom);
         excPc    = $urandom;
         irqReq   = ($urandom_range(0, 3) == 0);
         irqCause = 4'($urandom);
         irqPc    = $urandom;
         irqEn    = ($urandom_range(0, 3) != 0);
         mretReq  = ($urandom_range(0, 4) == 0);
         mtvecIn  = $urandom;
         mepcIn   = $urandom;
         if (i % 500 == 250) reset = 1'b0;
         else reset = 1'b1;
         step();
      end
      reset = 1'b1;
      excReq = 1'b0; irqReq = 1'b0; mretReq = 1'b0;
      repeat (4) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/trap_sequencer.md
Name: trap_sequencer

Overview:
- Initiator side of the machine-mode CSR trap interface. It drives the CSR file's dedicated mepc/mcause write ports and consumes its mtvec/mepc read-outs.
- Sits between the core's execute stage and the CSR file. It accepts synchronous exceptions, external interrupts and MRET, and sequences each into CSR writes plus a PC redirect. It stalls the pipeline while a sequence is in flight.

Parameters:
- XLEN, 32, data/address width of CSR values and PCs
- CAUSE_W, 4, width of the exception/interrupt cause codes accepted on input

Ports:
- clk  input  1  core clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- excReq  input  1  synchronous exception request, sampled only in IDLE
- excCause  input  CAUSE_W  exception code for excReq
- excPc  input  XLEN  PC of the faulting instruction
- irqReq  input  1  level-sensitive external interrupt request
- irqCause  input  CAUSE_W  interrupt code for irqReq
- irqPc  input  XLEN  PC of the next instruction to execute (saved on interrupt)
- irqEn  input  1  global machine interrupt enable (mstatus.MIE)
- mretReq  input  1  MRET instruction in execute
- mtvecIn  input  XLEN  current mtvec from the CSR file
- mepcIn  input  XLEN  current mepc from the CSR file
- mepcWe  output  1  mepc write strobe to the CSR file
- mepcDo  output  XLEN  value to write into mepc
- mcauseWe  output  1  mcause write strobe to the CSR file
- mcauseDo  output  XLEN  value to write into mcause
- redirectValid  output  1  one-cycle strobe: the fetch PC must load redirectPc
- redirectPc  output  XLEN  trap vector or return address
- busy  output  1  high whenever state is not IDLE; the pipeline must stall

Behaviour:
- States: IDLE, SAVE, VECTOR, RETURN. All outputs are registered/decoded from state plus captured registers.
- Reset (reset=0, asynchronous):
  - State goes to IDLE and all capture registers clear.
  - mepcWe=mcauseWe=redirectValid=busy=0; mepcDo=mcauseDo=redirectPc=0.
  - A reset mid-sequence aborts with no further CSR write or redirect.
- Acceptance happens in IDLE only. Priority is excReq > (irqReq & irqEn) > mretReq. Lower-priority requests in the same cycle are dropped; the interrupt stays visible because it is level-sensitive.
- Requests while busy=1 are ignored and not queued.
- Exception accepted at edge N:
  - Capture pcReg=excPc, causeReg={1'b0, zero-extend excCause}, isIrq=0; go to SAVE.
- Interrupt accepted at edge N:
  - Capture pcReg=irqPc, causeReg={1'b1, zero-extend irqCause}, isIrq=1; go to SAVE.
- SAVE (cycle N+1):
  - mepcWe=1 with mepcDo=pcReg&~3 (IALIGN=32, low 2 bits forced 0).
  - mcauseWe=1 with mcauseDo=causeReg.
  - Both strobes last exactly one cycle. Next state is VECTOR.
- VECTOR (cycle N+2):
  - redirectValid=1 for one cycle.
  - base={mtvecIn[XLEN-1:2],2'b00}, mode=mtvecIn[1:0].
  - If mode==1 and isIrq: redirectPc=base+4*irqCause. Otherwise redirectPc=base.
  - mode values 2/3 are treated as direct mode 0.
  - mtvecIn is sampled in this cycle, so an mtvec written in the same cycle as acceptance takes effect. Addition wraps modulo 2^XLEN.
  - Next state is IDLE. busy deasserts at N+3.
- MRET accepted at edge N: go to RETURN.
- RETURN (cycle N+1):
  - redirectValid=1, redirectPc=mepcIn&~3, no CSR writes.
  - Next state is IDLE.
- busy=1 exactly in SAVE, VECTOR and RETURN.
- mepcDo/mcauseDo hold their last value when the write strobes are low. Only the strobe qualifies them.
- Back-to-back: a request present in the IDLE cycle immediately after VECTOR/RETURN is accepted at that edge. There are no dead cycles beyond IDLE itself.

Test Plan:
- Reset: hold reset=0 with excReq=1 → all outputs 0, state IDLE. Release reset → the first rising edge with excReq=1 is accepted.
- Exception: excReq=1, excCause=2, excPc=0x00000103, mtvecIn=0x00000100.
  - SAVE: mepcWe=1, mepcDo=0x00000100, mcauseWe=1, mcauseDo=0x00000002.
  - Next cycle: redirectValid=1, redirectPc=0x00000100.
  - busy high for exactly 2 cycles.
- Vectored interrupt: irqReq=1, irqEn=1, irqCause=11, irqPc=0x40, mtvecIn=0x00000101.
  - mcauseDo=0x8000000B, mepcDo=0x40, redirectPc=0x0000012C.
  - Repeat with irqEn=0 → no activity, busy stays 0.
- Priority: excReq=1 (cause 4), irqReq=1/irqEn=1 and mretReq=1 in the same IDLE cycle → mcauseDo=0x00000004.
  - Then with irqReq still high → the interrupt is accepted the cycle after VECTOR.
- MRET: mepcIn=0x00000082, mretReq=1 → next cycle redirectValid=1, redirectPc=0x00000080, mepcWe=mcauseWe=0, busy high 1 cycle.
- Reset mid-sequence: assert reset=0 during SAVE → outputs clear immediately, no VECTOR strobe follows, busy=0.
